// File: rtl/afu_mmio_csr.sv
`default_nettype none
// ============================================================================
// Module      : afu_mmio_csr
// Description : AFU MMIO CSR block. It holds the DFH, AFU ID, scratch and job
//               descriptor registers, and runs the engine start/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module afu_mmio_csr #(
    parameter logic [63:0] AFU_ID_L = 64'h0,
    parameter logic [63:0] AFU_ID_H = 64'h0,
    parameter logic [63:0] DFH_VAL  = 64'h1000_0000_0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mmio_wr_valid,
    input  logic        mmio_rd_valid,
    input  logic [15:0] mmio_addr,
    input  logic [1:0]  mmio_len,
    input  logic [8:0]  mmio_tid,
    input  logic [63:0] mmio_wdata,
    output logic        rsp_valid,
    output logic [8:0]  rsp_tid,
    output logic [63:0] rsp_data,
    output logic        eng_start,
    output logic [63:0] eng_src_addr,
    output logic [63:0] eng_dst_addr,
    output logic [31:0] eng_len,
    input  logic        eng_done
);

    // 8-byte register indices (byte offset / 8)
    localparam logic [14:0] C_IDX_DFH     = 15'd0;
    localparam logic [14:0] C_IDX_ID_L    = 15'd1;
    localparam logic [14:0] C_IDX_ID_H    = 15'd2;
    localparam logic [14:0] C_IDX_SCRATCH = 15'd5;
    localparam logic [14:0] C_IDX_CTRL    = 15'd6;
    localparam logic [14:0] C_IDX_STATUS  = 15'd7;
    localparam logic [14:0] C_IDX_SRC     = 15'd8;
    localparam logic [14:0] C_IDX_DST     = 15'd9;
    localparam logic [14:0] C_IDX_LEN     = 15'd10;

    // Register state
    logic [63:0] r_scratch;
    logic [63:0] r_src;
    logic [63:0] r_dst;
    logic [31:0] r_len;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_done_cnt;
    logic        r_eng_start;

    // Read pipeline state
    logic        r_rd_v1;
    logic [14:0] r_rd_idx;
    logic        r_rd_odd;
    logic        r_rd_len8;
    logic [8:0]  r_rd_tid;
    logic        r_rsp_valid;
    logic [8:0]  r_rsp_tid;
    logic [63:0] r_rsp_data;

    // Write decode
    logic [14:0] w_wr_idx;
    logic        w_wr_len8;
    logic        w_wr_lo;
    logic        w_wr_hi;
    logic [31:0] w_lo_data;
    logic [31:0] w_hi_data;
    logic        w_ctrl_wr;
    logic        w_start_ok;
    logic        w_clr_req;

    // A 4 B write always carries its payload in [31:0]; route it to the addressed half.
    assign w_wr_idx   = mmio_addr[15:1];
    assign w_wr_len8  = (mmio_len != 2'd0);
    assign w_wr_lo    = w_wr_len8 | ~mmio_addr[0];
    assign w_wr_hi    = w_wr_len8 |  mmio_addr[0];
    assign w_lo_data  = mmio_wdata[31:0];
    assign w_hi_data  = w_wr_len8 ? mmio_wdata[63:32] : mmio_wdata[31:0];
    assign w_ctrl_wr  = mmio_wr_valid & (w_wr_idx == C_IDX_CTRL) & w_wr_lo;
    assign w_start_ok = w_ctrl_wr & w_lo_data[0] & ~r_busy;
    assign w_clr_req  = w_ctrl_wr & w_lo_data[1];

    // A start request while busy is dropped, so start and done never collide on busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_done_cnt  <= 32'd0;
            r_eng_start <= 1'b0;
        end else begin
            r_eng_start <= w_start_ok;
            if (w_start_ok) begin
                r_busy <= 1'b1;
            end else if (eng_done) begin
                r_busy <= 1'b0;
            end
            if (eng_done) begin
                r_done     <= 1'b1;
                r_done_cnt <= r_done_cnt + 32'd1;
            end else if (w_clr_req) begin
                r_done <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scratch <= 64'd0;
            r_src     <= 64'd0;
            r_dst     <= 64'd0;
            r_len     <= 32'd0;
        end else if (mmio_wr_valid) begin
            if (w_wr_idx == C_IDX_SCRATCH) begin
                if (w_wr_lo) r_scratch[31:0]  <= w_lo_data;
                if (w_wr_hi) r_scratch[63:32] <= w_hi_data;
            end
            if (w_wr_idx == C_IDX_SRC) begin
                if (w_wr_lo) r_src[31:0]  <= w_lo_data;
                if (w_wr_hi) r_src[63:32] <= w_hi_data;
            end
            if (w_wr_idx == C_IDX_DST) begin
                if (w_wr_lo) r_dst[31:0]  <= w_lo_data;
                if (w_wr_hi) r_dst[63:32] <= w_hi_data;
            end
            if ((w_wr_idx == C_IDX_LEN) && w_wr_lo) begin
                r_len <= w_lo_data;
            end
        end
    end

    // Read stage 1: capture the request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_v1   <= 1'b0;
            r_rd_idx  <= 15'd0;
            r_rd_odd  <= 1'b0;
            r_rd_len8 <= 1'b0;
            r_rd_tid  <= 9'd0;
        end else begin
            r_rd_v1 <= mmio_rd_valid;
            if (mmio_rd_valid) begin
                r_rd_idx  <= mmio_addr[15:1];
                r_rd_odd  <= mmio_addr[0];
                r_rd_len8 <= (mmio_len != 2'd0);
                r_rd_tid  <= mmio_tid;
            end
        end
    end

    logic [63:0] w_rd_reg;
    logic [63:0] w_rd_data;

    always_comb begin
        w_rd_reg = 64'd0;
        case (r_rd_idx)
            C_IDX_DFH:     w_rd_reg = DFH_VAL;
            C_IDX_ID_L:    w_rd_reg = AFU_ID_L;
            C_IDX_ID_H:    w_rd_reg = AFU_ID_H;
            C_IDX_SCRATCH: w_rd_reg = r_scratch;
            C_IDX_STATUS:  w_rd_reg = {r_done_cnt, 30'd0, r_done, r_busy};
            C_IDX_SRC:     w_rd_reg = r_src;
            C_IDX_DST:     w_rd_reg = r_dst;
            C_IDX_LEN:     w_rd_reg = {32'd0, r_len};
            default:       w_rd_reg = 64'd0;
        endcase
    end

    always_comb begin
        w_rd_data = w_rd_reg;
        if (!r_rd_len8) begin
            w_rd_data = {32'd0, (r_rd_odd ? w_rd_reg[63:32] : w_rd_reg[31:0])};
        end
    end

    // Read stage 2: register the muxed data; this samples writes from the request cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_tid   <= 9'd0;
            r_rsp_data  <= 64'd0;
        end else begin
            r_rsp_valid <= r_rd_v1;
            if (r_rd_v1) begin
                r_rsp_tid  <= r_rd_tid;
                r_rsp_data <= w_rd_data;
            end
        end
    end

    assign rsp_valid    = r_rsp_valid;
    assign rsp_tid      = r_rsp_tid;
    assign rsp_data     = r_rsp_data;
    assign eng_start    = r_eng_start;
    assign eng_src_addr = r_src;
    assign eng_dst_addr = r_dst;
    assign eng_len      = r_len;

endmodule
`default_nettype wire

// File: tb/tb_afu_mmio_csr.sv
`default_nettype none
// ============================================================================
// Module      : tb_afu_mmio_csr
// Description : Directed and random bench for afu_mmio_csr with a register-map model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_afu_mmio_csr;

    localparam logic [63:0] C_ID_L = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] C_ID_H = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] C_DFH  = 64'h1000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mmio_wr_valid;
    logic        mmio_rd_valid;
    logic [15:0] mmio_addr;
    logic [1:0]  mmio_len;
    logic [8:0]  mmio_tid;
    logic [63:0] mmio_wdata;
    logic        rsp_valid;
    logic [8:0]  rsp_tid;
    logic [63:0] rsp_data;
    logic        eng_start;
    logic [63:0] eng_src_addr;
    logic [63:0] eng_dst_addr;
    logic [31:0] eng_len;
    logic        eng_done;

    always #5 clk = ~clk;

    afu_mmio_csr #(
        .AFU_ID_L(C_ID_L),
        .AFU_ID_H(C_ID_H),
        .DFH_VAL (C_DFH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mmio_wr_valid(mmio_wr_valid),
        .mmio_rd_valid(mmio_rd_valid),
        .mmio_addr    (mmio_addr),
        .mmio_len     (mmio_len),
        .mmio_tid     (mmio_tid),
        .mmio_wdata   (mmio_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_tid      (rsp_tid),
        .rsp_data     (rsp_data),
        .eng_start    (eng_start),
        .eng_src_addr (eng_src_addr),
        .eng_dst_addr (eng_dst_addr),
        .eng_len      (eng_len),
        .eng_done     (eng_done)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [63:0] m_scratch, m_src, m_dst;
    logic [31:0] m_len, m_cnt;
    logic        m_busy, m_done;
    // Read issued in the previous cycle, whose response is due after the next edge
    logic        p_v;
    logic [8:0]  p_tid;
    logic [63:0] p_data;
    logic [63:0] last_data;
    logic [8:0]  last_tid;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_scratch = 64'd0; m_src = 64'd0; m_dst = 64'd0;
        m_len = 32'd0; m_cnt = 32'd0; m_busy = 1'b0; m_done = 1'b0;
        p_v = 1'b0; p_tid = 9'd0; p_data = 64'd0;
    endtask

    function automatic logic [63:0] reg_at(input int idx);
        case (idx)
            0:  return C_DFH;
            1:  return C_ID_L;
            2:  return C_ID_H;
            5:  return m_scratch;
            7:  return {m_cnt, 30'd0, m_done, m_busy};
            8:  return m_src;
            9:  return m_dst;
            10: return {32'd0, m_len};
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [63:0] rd_model(input logic [15:0] addr, input logic [1:0] len);
        logic [63:0] v;
        v = reg_at(int'(addr) / 2);
        if (len == 2'd0) return addr[0] ? {32'd0, v[63:32]} : {32'd0, v[31:0]};
        return v;
    endfunction

    // One clock cycle: drive request, advance model, then check outputs 1 ns after the edge.
    task automatic step(input logic wr, input logic rd, input logic [15:0] addr,
                        input logic [1:0] len, input logic [8:0] tid,
                        input logic [63:0] wd, input logic done);
        int          idx;
        logic [63:0] old_v, new_v;
        logic        start_req, clr_req, exp_start;
        logic        cur_v;
        logic [8:0]  cur_tid;
        logic [63:0] cur_data;
        mmio_wr_valid = wr; mmio_rd_valid = rd; mmio_addr = addr;
        mmio_len = len; mmio_tid = tid; mmio_wdata = wd; eng_done = done;
        idx = int'(addr) / 2;
        start_req = 1'b0; clr_req = 1'b0;
        if (wr) begin
            old_v = (idx == 6) ? 64'd0 : reg_at(idx);
            if (len != 2'd0)  new_v = wd;
            else if (addr[0]) new_v = {wd[31:0], old_v[31:0]};
            else              new_v = {old_v[63:32], wd[31:0]};
            case (idx)
                5:  m_scratch = new_v;
                6:  begin start_req = new_v[0]; clr_req = new_v[1]; end
                8:  m_src = new_v;
                9:  m_dst = new_v;
                10: m_len = new_v[31:0];
                default: ;
            endcase
        end
        exp_start = start_req && !m_busy;
        if (clr_req) m_done = 1'b0;
        if (done) begin
            m_done = 1'b1;
            m_cnt  = m_cnt + 32'd1;
            m_busy = 1'b0;
        end
        if (exp_start) m_busy = 1'b1;
        cur_v = rd; cur_tid = tid;
        cur_data = rd ? rd_model(addr, len) : 64'd0;

        @(posedge clk); #1;
        chk("rsp_valid", {63'd0, rsp_valid}, {63'd0, p_v});
        if (p_v) begin
            chk("rsp_tid", {55'd0, rsp_tid}, {55'd0, p_tid});
            chk("rsp_data", rsp_data, p_data);
        end
        if (rsp_valid) begin
            last_data = rsp_data;
            last_tid  = rsp_tid;
        end
        chk("eng_start", {63'd0, eng_start}, {63'd0, exp_start});
        chk("eng_src_addr", eng_src_addr, m_src);
        chk("eng_dst_addr", eng_dst_addr, m_dst);
        chk("eng_len", {32'd0, eng_len}, {32'd0, m_len});
        p_v = cur_v; p_tid = cur_tid; p_data = cur_data;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'd0, 2'd0, 9'd0, 64'd0, 1'b0);
    endtask

    task automatic wr8(input logic [15:0] dw, input logic [63:0] d);
        step(1'b1, 1'b0, dw, 2'd1, 9'd0, d, 1'b0);
    endtask

    task automatic rd_wait(input logic [15:0] dw, input logic [1:0] len, input logic [8:0] tid);
        step(1'b0, 1'b1, dw, len, tid, 64'd0, 1'b0);
        idle(2);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd0);
        chk({tag, "_rsp_tid"}, {55'd0, rsp_tid}, 64'd0);
        chk({tag, "_rsp_data"}, rsp_data, 64'd0);
        chk({tag, "_eng_start"}, {63'd0, eng_start}, 64'd0);
        chk({tag, "_src"}, eng_src_addr, 64'd0);
        chk({tag, "_dst"}, eng_dst_addr, 64'd0);
        chk({tag, "_len"}, {32'd0, eng_len}, 64'd0);
    endtask

    initial begin
        logic [63:0] d;
        rst_n = 1'b0;
        mmio_wr_valid = 1'b0; mmio_rd_valid = 1'b0; mmio_addr = 16'd0;
        mmio_len = 2'd0; mmio_tid = 9'd0; mmio_wdata = 64'd0; eng_done = 1'b0;
        last_data = 64'd0; last_tid = 9'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // Identity reads
        rd_wait(16'h0000, 2'd1, 9'd5);
        chk("dfh_data", last_data, C_DFH);
        chk("dfh_tid", {55'd0, last_tid}, 64'd5);
        rd_wait(16'h0002, 2'd1, 9'd6);
        chk("id_l", last_data, C_ID_L);
        rd_wait(16'h0004, 2'd1, 9'd7);
        chk("id_h", last_data, C_ID_H);
        rd_wait(16'h0016, 2'd1, 9'd8);
        chk("unmapped", last_data, 64'd0);

        // Scratch access widths
        wr8(16'h000A, 64'hDEAD_BEEF_CAFE_F00D);
        rd_wait(16'h000A, 2'd1, 9'd9);
        chk("scratch8", last_data, 64'hDEAD_BEEF_CAFE_F00D);
        step(1'b1, 1'b0, 16'h000B, 2'd0, 9'd0, 64'h0000_0000_1234_5678, 1'b0);
        rd_wait(16'h000A, 2'd1, 9'd10);
        chk("scratch_hi4", last_data, 64'h1234_5678_CAFE_F00D);
        rd_wait(16'h000A, 2'd0, 9'd11);
        chk("scratch_rd4", last_data, 64'h0000_0000_CAFE_F00D);

        // Job start/done/clear
        wr8(16'h0010, 64'h1000);
        wr8(16'h0012, 64'h2000);
        wr8(16'h0014, 64'd16);
        wr8(16'h000C, 64'd1);
        chk("start_pulse", {63'd0, eng_start}, 64'd1);
        idle(1);
        chk("start_once", {63'd0, eng_start}, 64'd0);
        rd_wait(16'h000E, 2'd1, 9'd12);
        chk("status_busy", last_data, 64'h1);
        wr8(16'h000C, 64'd1);
        chk("start_while_busy", {63'd0, eng_start}, 64'd0);
        step(1'b0, 1'b0, 16'd0, 2'd0, 9'd0, 64'd0, 1'b1);
        rd_wait(16'h000E, 2'd1, 9'd13);
        chk("status_done", last_data, 64'h1_0000_0002);
        wr8(16'h000C, 64'd2);
        rd_wait(16'h000E, 2'd1, 9'd14);
        chk("status_cleared", last_data, 64'h1_0000_0000);

        // Simultaneous events
        wr8(16'h000C, 64'd1);
        step(1'b1, 1'b0, 16'h000C, 2'd1, 9'd0, 64'd1, 1'b1);
        chk("start_with_done", {63'd0, eng_start}, 64'd0);
        rd_wait(16'h000E, 2'd1, 9'd15);
        chk("status_lo_after_both", {62'd0, last_data[1:0]}, 64'd2);
        step(1'b1, 1'b0, 16'h000C, 2'd1, 9'd0, 64'd2, 1'b1);
        rd_wait(16'h000E, 2'd1, 9'd16);
        chk("done_beats_clear", {63'd0, last_data[1]}, 64'd1);

        // Pipelined reads and same-cycle write/read
        step(1'b0, 1'b1, 16'h000A, 2'd1, 9'd1, 64'd0, 1'b0);
        step(1'b0, 1'b1, 16'h000E, 2'd1, 9'd2, 64'd0, 1'b0);
        step(1'b0, 1'b1, 16'h0010, 2'd1, 9'd3, 64'd0, 1'b0);
        step(1'b0, 1'b1, 16'h0000, 2'd1, 9'd4, 64'd0, 1'b0);
        idle(2);
        chk("pipe_last_tid", {55'd0, last_tid}, 64'd4);
        step(1'b1, 1'b1, 16'h000A, 2'd1, 9'd20, 64'h5A5A_A5A5_0F0F_F0F0, 1'b0);
        idle(2);
        chk("wr_rd_same_cycle", last_data, 64'h5A5A_A5A5_0F0F_F0F0);

        // Reset with a read in flight
        step(1'b0, 1'b1, 16'h000A, 2'd1, 9'd21, 64'd0, 1'b0);
        rst_n = 1'b0;
        #2;
        chk_reset_outputs("async_reset");
        mmio_rd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        idle(3);
        for (int a = 0; a < 24; a += 2) rd_wait(16'(a), 2'd1, 9'(a));
        chk("status_after_reset", last_data, 64'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [15:0] ra;
            logic [63:0] rw;
            ra = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 23));
            rw = {$urandom, $urandom};
            if ($urandom_range(0, 2) == 0) rw[1:0] = 2'($urandom_range(0, 3));
            step(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), ra,
                 2'($urandom_range(0, 3)), 9'($urandom), rw,
                 1'($urandom_range(0, 7) == 0));
        end
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
